mdu_ex: RTL and testbench

MDU_EX -- requirements
Module: mdu_ex

---
 rtl/mdu_ex.sv | 115 +++++++++++
 tb/tb_mdu_ex.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ex.sv
// MIPS EX-stage multiply/divide unit owning HI/LO; optional accumulate ops enabled by MDU_MADD_EN.
// Latency: mult/madd results land on HI/LO MULT_CYCLES edges after start, div results DIV_CYCLES edges after start, mthi/mtlo on the start edge.
// Backpressure: busy is high while an op is in flight and start is ignored then; the pipeline stalls on busy | (start & MD op).
module mdu_ex #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDop,
    input  logic [31:0] md1,
    input  logic [31:0] md2,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   shi, slo;

    logic          is_signed, a_neg, b_neg, b_zero;
    logic [31:0]   a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
    logic [63:0]   prod_mag, prod, res;
    logic          launch;
    logic [CW-1:0] ncyc;

    // One unsigned multiplier/divider on magnitudes; signs are restored afterwards.
    always_comb begin
        is_signed = ~MDop[0];
        a_neg     = is_signed & md1[31];
        b_neg     = is_signed & md2[31];
        a_mag     = a_neg ? (~md1 + 32'd1) : md1;
        b_mag     = b_neg ? (~md2 + 32'd1) : md2;
        b_zero    = (md2 == 32'd0);
        b_div     = b_zero ? 32'd1 : b_mag;
        q_mag     = a_mag / b_div;
        r_mag     = a_mag % b_div;
        quo       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem       = a_neg ? (~r_mag + 32'd1) : r_mag;
        prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
        prod      = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;

        launch = 1'b0;
        ncyc   = '0;
        res    = {HI, LO};
        case (MDop)
            4'd0, 4'd1: begin
                launch = 1'b1;
                ncyc   = CW'(MULT_CYCLES);
                res    = prod;
            end
            4'd2, 4'd3: begin
                launch = 1'b1;
                ncyc   = CW'(DIV_CYCLES);
                // Zero divisor still occupies the unit but recommits the old HI/LO.
                res    = b_zero ? {HI, LO} : {rem, quo};
            end
`ifdef MDU_MADD_EN
            4'd4, 4'd5, 4'd6, 4'd7: begin
                launch = 1'b1;
                ncyc   = CW'(MULT_CYCLES);
                res    = MDop[1] ? ({HI, LO} - prod) : ({HI, LO} + prod);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            shi   <= 32'd0;
            slo   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (MDop == 4'd8) begin
                            HI <= md1;
                        end else if (MDop == 4'd9) begin
                            LO <= md1;
                        end else if (launch) begin
                            shi   <= res[63:32];
                            slo   <= res[31:0];
                            cnt   <= ncyc;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        HI    <= shi;
                        LO    <= slo;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ex.sv
// Self-checking bench for mdu_ex: vector table plus hand sequences for restart-while-busy and mid-op reset.
module tb_mdu_ex;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  MDop;
    logic [31:0] md1, md2;
    logic        busy;
    logic [31:0] HI, LO;

    mdu_ex #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDop  (MDop),
        .md1   (md1),
        .md2   (md2),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] phi;
        logic [31:0] plo;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [7:0]  cyc;
    } vec_t;

    localparam int NV = 12;
    vec_t        vec [NV];
    logic [63:0] sb [$];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDop  = op;
        md1   = a;
        md2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input int i);
        int          n;
        logic [63:0] exp;
        issue(4'd8, vec[i].phi, 32'd0);
        issue(4'd9, vec[i].plo, 32'd0);
        chk($sformatf("v%0d_preload", i), {31'd0, busy, HI, LO}, {31'd0, 1'b0, vec[i].phi, vec[i].plo});
        sb.push_back({vec[i].ehi, vec[i].elo});
        issue(vec[i].op, vec[i].a, vec[i].b);
        wait_idle(n);
        chk($sformatf("v%0d_busy_cycles", i), 64'(n), 64'(vec[i].cyc));
        exp = sb.pop_front();
        chk($sformatf("v%0d_hilo", i), {HI, LO}, exp);
    endtask

    initial begin
        int n;
        logic [63:0] exp;

        vec[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, 8'd5};
        vec[1]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFE, 32'h00000001, 8'd5};
        vec[2]  = '{4'd0, 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 32'hC0000000, 32'h80000000, 8'd5};
        vec[3]  = '{4'd3, 32'd100,      32'd7,        32'd0, 32'd0, 32'd2,        32'd14,       8'd10};
        vec[4]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 8'd10};
        vec[5]  = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd0, 32'd0, 32'd1,        32'hFFFFFFFD, 8'd10};
        vec[6]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1, 32'd0,        32'h80000000, 8'd10};
        vec[7]  = '{4'd2, 32'd55,       32'd0,        32'd5, 32'd6, 32'd5,        32'd6,        8'd10};
        vec[8]  = '{4'd12, 32'd9,       32'd9,        32'd1, 32'd2, 32'd1,        32'd2,        8'd0};
        vec[9]  = '{4'd6, 32'd1,        32'hA,        32'h12345678, 32'h9,
                    MADD ? 32'h12345677 : 32'h12345678, MADD ? 32'hFFFFFFFF : 32'h9, MADD ? 8'd5 : 8'd0};
        vec[10] = '{4'd5, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF,
                    MADD ? 32'd0 : 32'hFFFFFFFF, MADD ? 32'd0 : 32'hFFFFFFFF, MADD ? 8'd5 : 8'd0};
        vec[11] = '{4'd4, 32'hFFFFFFFF, 32'd3,        32'd0, 32'd5,
                    32'd0, MADD ? 32'd2 : 32'd5, MADD ? 8'd5 : 8'd0};

        reset = 1'b1;
        start = 1'b0;
        MDop  = 4'd0;
        md1   = 32'd0;
        md2   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_state", {31'd0, busy, HI, LO}, 97'd0);

        for (int i = 0; i < NV; i++) run_vec(i);

        // A second start two cycles into a busy mult must be dropped.
        issue(4'd8, 32'd0, 32'd0);
        issue(4'd9, 32'd0, 32'd0);
        sb.push_back(64'd10);
        issue(4'd0, 32'd2, 32'd5);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin
                start = 1'b1;
                MDop  = 4'd0;
                md1   = 32'd3;
                md2   = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("restart_busy_cycles", 64'(n), 64'd5);
        exp = sb.pop_front();
        chk("restart_hilo", {HI, LO}, exp);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("restart_idle%0d", k), {31'd0, busy, HI, LO}, {32'd0, 32'd0, 32'd10});
        end

        // Reset in the middle of a divide clears HI/LO at once and nothing commits later.
        issue(4'd8, 32'hAAAA5555, 32'd0);
        issue(4'd9, 32'h5555AAAA, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #3;
        chk("midrun_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("midrun_async_clear", {31'd0, busy, HI, LO}, 97'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("midrun_no_commit", {31'd0, busy, HI, LO}, 97'd0);

        // Unit still works after the abort.
        sb.push_back({32'd2, 32'd14});
        issue(4'd3, 32'd100, 32'd7);
        wait_idle(n);
        chk("post_reset_cycles", 64'(n), 64'd10);
        exp = sb.pop_front();
        chk("post_reset_hilo", {HI, LO}, exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
